// File: rtl/fifo_uart_tx_pkg.sv
// Purpose : shared state encoding and framing constants for the FIFO-fed UART transmitter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package fifo_uart_tx_pkg;

    // Controller states: fetch a byte (POP, WAIT), then serialise it (START, DATA, STOP).
    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // 8N1 frame: one start bit, eight data bits, one stop bit.
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Purpose : bit-period timer; tick marks the last clk cycle of each serial bit.
// Latency : tick rises CLKS_PER_BIT-1 cycles after clear is released.
// Backpressure: none; clear holds the count at 0 while no bit is being sent.
//
// Ports: clk, rst (sync, active high), clear (hold count at 0), tick (last cycle of a bit).
module baud_counter
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = !clear && (cnt_q == LAST);

    // Restart at 0 on every bit boundary so the count never runs past LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Purpose : pops bytes from an upstream registered-read FIFO and sends them as 8N1 frames, LSB first.
// Latency : fifo_rd_en 1 edge and tx start bit 3 edges after an IDLE cycle with tx_en=1 and fifo_empty=0.
// Backpressure: a frame is only started when tx_en=1 and the FIFO is non-empty; a started frame always completes.
//
// Ports: clk, rst (sync, active high), tx_en, fifo_empty, fifo_data[7:0] (valid the cycle after a pop),
//        fifo_rd_en (one-cycle pop), tx (serial line, idle high), busy, frame_count[7:0] (completed frames).
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frame_count
);

    state_t     state_q,   state_d;
    logic [7:0] shift_q,   shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] count_q,   count_d;
    logic       tx_q,      tx_d;
    logic       rd_en_q,   rd_en_d;

    logic bit_clear;
    logic tick;

    // The bit timer only runs while a frame is on the line.
    assign bit_clear = (state_q == IDLE) || (state_q == POP) || (state_q == WAIT);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(bit_clear),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        count_d   = count_q;

        unique case (state_q)
            IDLE: begin
                // fifo_empty is only looked at here; later changes cannot affect a frame.
                if (tx_en && !fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Registered FIFO read data is valid in the cycle after the pop.
                shift_d   = fifo_data;
                bit_idx_d = '0;
                state_d   = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT_IDX) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    count_d = count_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        rd_en_d = (state_d == POP);
        tx_d    = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            count_q   <= '0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            count_q   <= count_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign fifo_rd_en  = rd_en_q;
    assign tx          = tx_q;
    assign busy        = (state_q != IDLE);
    assign frame_count = count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Purpose : self-checking bench for fifo_uart_tx with a frame-timeline model and directed literal checks.
// Latency : n/a.
// Backpressure: n/a.
module tb_fifo_uart_tx;

    localparam int N     = 4;
    localparam int FRAME = 10 * N;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       tx_en     = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic [7:0] frame_count;

    logic [7:0] mem [512];
    int         wr_ptr    = 0;
    int         rd_ptr    = 0;
    int         rd_pulses = 0;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: m_t = clk edges since the frame's pop began (0 = idle).
    int         m_t    = 0;
    int         m_rd   = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_cnt  = 8'h00;

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Upstream FIFO with registered read data.
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr % 512];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_t   = 0;
            m_cnt = 8'h00;
        end else if (m_t == 0) begin
            if (tx_en && (m_rd != wr_ptr)) begin
                m_t    = 1;
                m_byte = mem[m_rd % 512];
                m_rd++;
            end
        end else if (m_t == FRAME + 2) begin
            m_t = 0;
            m_cnt++;
        end else begin
            m_t++;
        end
    end

    // Line level at edge t of a frame: pop/wait high, then start, 8 data bits LSB first, stop.
    function automatic logic exp_tx(int t, logic [7:0] b);
        int k;
        if (t < 3) return 1'b1;
        k = (t - 3) / N;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx", {31'd0, tx}, {31'd0, exp_tx(m_t, m_byte)});
            check("model_busy", {31'd0, busy}, {31'd0, m_t != 0});
            check("model_rd_en", {31'd0, fifo_rd_en}, {31'd0, m_t == 1});
            check("model_frame_count", {24'd0, frame_count}, {24'd0, m_cnt});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(logic [7:0] b);
        mem[wr_ptr % 512] = b;
        wr_ptr++;
    endtask

    initial begin
        int         p0;
        logic [9:0] pat;

        // Reset state.
        tick();
        chk_en = 1'b1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_frame_count", {24'd0, frame_count}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single byte 0xA5 and pop-to-start latency.
        p0 = rd_pulses;
        push(8'hA5);
        tx_en = 1'b1;
        tick();
        check("lat_rd_en_edge1", {31'd0, fifo_rd_en}, 32'd1);
        check("lat_tx_edge1", {31'd0, tx}, 32'd1);
        tick();
        check("lat_rd_en_edge2", {31'd0, fifo_rd_en}, 32'd0);
        check("lat_tx_edge2", {31'd0, tx}, 32'd1);
        tick();
        check("lat_tx_low_edge3", {31'd0, tx}, 32'd0);
        pat = 10'b1101001010;
        for (int i = 0; i < 10; i++) begin
            check("a5_bit", {31'd0, tx}, {31'd0, pat[i]});
            repeat (N) tick();
        end
        check("a5_frame_count", {24'd0, frame_count}, 32'd1);
        check("a5_busy_done", {31'd0, busy}, 32'd0);
        check("a5_rd_pulses", rd_pulses - p0, 32'd1);
        tx_en = 1'b0;
        repeat (5) tick();

        // Reset held 3 cycles in the middle of DATA.
        push(8'h3C);
        tx_en = 1'b1;
        repeat (20) tick();
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst   = 1'b1;
        tx_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_tx", {31'd0, tx}, 32'd1);
            check("midrst_busy", {31'd0, busy}, 32'd0);
            check("midrst_frame_count", {24'd0, frame_count}, 32'd0);
            check("midrst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        end
        rst = 1'b0;
        repeat (20) tick();
        check("midrst_tx_after", {31'd0, tx}, 32'd1);

        // Burst of three bytes with 3 idle-high cycles between frames.
        tx_en = 1'b1;
        p0 = rd_pulses;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        repeat (42) tick();
        check("burst_stop_tx", {31'd0, tx}, 32'd1);
        tick();
        check("burst_gap_idle_tx", {31'd0, tx}, 32'd1);
        check("burst_gap_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        check("burst_gap_pop_tx", {31'd0, tx}, 32'd1);
        check("burst_gap_pop_rd", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        check("burst_gap_wait_tx", {31'd0, tx}, 32'd1);
        tick();
        check("burst_f2_start_tx", {31'd0, tx}, 32'd0);
        repeat (129 - 46) tick();
        check("burst_frame_count", {24'd0, frame_count}, 32'd3);
        check("burst_rd_pulses", rd_pulses - p0, 32'd3);
        check("burst_busy_done", {31'd0, busy}, 32'd0);

        // Gating by tx_en.
        tx_en = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        p0 = rd_pulses;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("gate_tx_idle", {31'd0, tx}, 32'd1);
            check("gate_rd_idle", {31'd0, fifo_rd_en}, 32'd0);
        end
        tx_en = 1'b1;
        repeat (66) tick();
        check("gate_busy_f2", {31'd0, busy}, 32'd1);
        tx_en = 1'b0;
        repeat (60) tick();
        check("gate_frame_count", {24'd0, frame_count}, 32'd5);
        check("gate_rd_pulses", rd_pulses - p0, 32'd2);
        check("gate_fifo_left", {31'd0, fifo_empty}, 32'd0);

        // frame_count wrap over 256 frames, then an empty FIFO.
        rst = 1'b1;
        tick();
        check("wrap_rst_frame_count", {24'd0, frame_count}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 255; i++) push(8'(i));
        tx_en = 1'b1;
        repeat (255 * (FRAME + 3) - 1) tick();
        check("wrap_frame_count_254", {24'd0, frame_count}, 32'd254);
        tick();
        check("wrap_frame_count_255", {24'd0, frame_count}, 32'd255);
        repeat (FRAME + 3) tick();
        check("wrap_frame_count_0", {24'd0, frame_count}, 32'd0);
        check("wrap_fifo_drained", {31'd0, fifo_empty}, 32'd1);
        p0 = rd_pulses;
        repeat (100) tick();
        check("empty_no_rd", rd_pulses - p0, 32'd0);
        check("empty_tx_high", {31'd0, tx}, 32'd1);
        check("empty_busy", {31'd0, busy}, 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port tx_en, input, 1 bit: permits starting a new frame.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: empty flag from the upstream 8-bit FIFO.
REQ-007 The block SHALL have port fifo_data, input, 8 bits: FIFO registered read data, valid the cycle after a pop.
REQ-008 The block SHALL have port fifo_rd_en, output, 1 bit: one-cycle pop request to the FIFO.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, 8N1, idle high, LSB first.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The block SHALL have port frame_count, output, 8 bits: count of completed frames.

Function
REQ-012 States SHALL be IDLE, POP, WAIT, START, DATA, STOP; all outputs SHALL be registered or decoded from state only (Moore).
REQ-013 IDLE SHALL go to POP when tx_en=1 and fifo_empty=0; otherwise it SHALL stay in IDLE.
REQ-014 POP SHALL assert fifo_rd_en for exactly one cycle and SHALL then go to WAIT unconditionally.
REQ-015 WAIT SHALL capture fifo_data into the 8-bit shift register and SHALL then go to START.
REQ-016 fifo_rd_en SHALL never be high outside POP, and SHALL never be high on two consecutive cycles.
REQ-017 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-018 DATA SHALL drive the 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index 0..7, then go to STOP.
REQ-019 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, increment frame_count (mod 256, 255->0) on its last cycle, then go to IDLE.
REQ-020 tx SHALL be 1 in IDLE, POP and WAIT.
REQ-021 tx SHALL fall on the 3rd rising edge after the IDLE cycle in which the pop condition is true.
REQ-022 The frame (START through STOP) SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-023 Back-to-back frames from a non-empty FIFO SHALL be separated by exactly 3 idle-high cycles (IDLE, POP, WAIT).
REQ-024 Deasserting tx_en mid-frame SHALL NOT abort the frame; the block SHALL finish STOP and then remain in IDLE.
REQ-025 fifo_empty SHALL be sampled only in IDLE; a change of fifo_empty in other states SHALL have no effect.
REQ-026 The baud counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every state or bit change, and SHALL never wrap mid-bit.

Reset
REQ-027 On rst=1 at a rising edge, the block SHALL set state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_count=0, baud counter=0, bit index=0, shift register=0.
REQ-028 rst SHALL take priority over every transition.
REQ-029 A reset mid-frame SHALL drop the byte in flight without re-queuing it, with tx high on the cycle after the reset edge.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the default CLKS_PER_BIT, and the frame bit-count constant (10).
REQ-031 The baud counter SHALL be one sub-module, baud_counter, parameterised by CLKS_PER_BIT, with inputs clk, rst and clear and output tick (last cycle of a bit).
REQ-032 The counter width SHALL be $clog2(CLKS_PER_BIT).

Verification
REQ-033 The bench SHALL cover reset: hold rst 3 cycles mid-DATA -> tx=1, busy=0, frame_count=0, fifo_rd_en=0 from the next edge on.
REQ-034 The bench SHALL cover a single byte: FIFO holds 0xA5, CLKS_PER_BIT=4, tx_en=1 -> one fifo_rd_en pulse; tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1; frame_count=1.
REQ-035 The bench SHALL cover a burst: FIFO holds 0x00, 0xFF, 0x55 -> three frames, each 40 cycles, with exactly 3 high cycles between frames; 3 rd_en pulses; frame_count=3.
REQ-036 The bench SHALL cover gating: tx_en=0 with a non-empty FIFO -> no fifo_rd_en and tx stays 1 for 100 cycles; drop tx_en during the 2nd frame -> that frame completes and no 3rd pop occurs.
REQ-037 The bench SHALL cover wrap: 256 frames -> frame_count 255 then 0; an empty FIFO -> fifo_rd_en never asserts.
REQ-038 The bench SHALL cover latency: fifo_empty falls in IDLE -> fifo_rd_en 1 edge later and tx low 3 edges later.
